// File: rtl/cp0_ext.sv
// MIPS-style CP0 subset: SR/Cause/EPC/PRId, exception/interrupt capture, optional Count/Compare timer (CP0_TIMER_EN).
// Latency: reads and req are combinational, register updates land on the next edge. No backpressure: req is a level.
// Optional feature macro: CP0_TIMER_EN.
module cp0_ext #(
  parameter int          HW_INT_N = 6,
  parameter logic [31:0] PRID     = 32'h0000_2024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [4:0]          CP0_Addr,
  input  logic [31:0]         CP0_In,
  input  logic [31:0]         VPC,
  input  logic                BDIn,
  input  logic [4:0]          ExcCodeIn,
  input  logic [HW_INT_N-1:0] HWInt,
  input  logic                EXLClr,
  output logic [31:0]         CP0_Out,
  output logic [31:0]         EPC_Out,
  output logic                req,
  output logic                TimerIRQ
);

  localparam int IPH = 10 + HW_INT_N - 1;

  logic [HW_INT_N-1:0] sr_im;
  logic                sr_exl;
  logic                sr_ie;
  logic                cause_bd;
  logic [HW_INT_N-1:0] cause_ip;
  logic [4:0]          cause_exc;
  logic [31:0]         epc;
  logic                timer_flag;
  logic [HW_INT_N-1:0] ip_in;
  logic [31:0]         sr_word;
  logic [31:0]         cause_word;
  logic                int_req;
  logic                exc_req;
  logic                wr;

  assign int_req = (|(cause_ip & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = (ExcCodeIn != 5'd0) & ~sr_exl;
  assign req     = int_req | exc_req;
  // A pending exception/interrupt swallows any mtc0 issued in the same cycle.
  assign wr      = en & ~req;

  assign EPC_Out  = epc;
  assign TimerIRQ = timer_flag;

  always_comb begin
    ip_in = HWInt;
    ip_in[HW_INT_N-1] = HWInt[HW_INT_N-1] | timer_flag;
  end

  always_comb begin
    sr_word        = '0;
    sr_word[IPH:10] = sr_im;
    sr_word[1]     = sr_exl;
    sr_word[0]     = sr_ie;
    cause_word         = '0;
    cause_word[31]     = cause_bd;
    cause_word[IPH:10] = cause_ip;
    cause_word[6:2]    = cause_exc;
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      compare    <= '0;
      timer_flag <= 1'b0;
    end else begin
      count <= (wr && CP0_Addr == 5'd9) ? CP0_In : count + 32'd1;
      if (wr && CP0_Addr == 5'd11) begin
        compare    <= CP0_In;
        timer_flag <= 1'b0;
      end else if (count == compare) begin
        timer_flag <= 1'b1;
      end
    end
  end
`else
  assign timer_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= ip_in;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_exc <= int_req ? 5'd0 : ExcCodeIn;
        cause_bd  <= BDIn;
        epc       <= (VPC & 32'hFFFF_FFFC) - (BDIn ? 32'd4 : 32'd0);
      end else begin
        if (en && CP0_Addr == 5'd12) begin
          sr_im  <= CP0_In[IPH:10];
          sr_exl <= CP0_In[1];
          sr_ie  <= CP0_In[0];
        end
        if (en && CP0_Addr == 5'd14) epc <= CP0_In;
        // eret overrides an EXL value written by a simultaneous mtc0 SR.
        if (EXLClr) sr_exl <= 1'b0;
      end
    end
  end

  always_comb begin
    CP0_Out = '0;
    case (CP0_Addr)
      5'd12:   CP0_Out = sr_word;
      5'd13:   CP0_Out = cause_word;
      5'd14:   CP0_Out = epc;
      5'd15:   CP0_Out = PRID;
`ifdef CP0_TIMER_EN
      5'd9:    CP0_Out = count;
      5'd11:   CP0_Out = compare;
`endif
      default: CP0_Out = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_ext.sv
// Bench for cp0_ext: directed scenarios plus random traffic checked against a word-level CP0 model via a scoreboard.
module tb_cp0_ext;
  localparam int          N = 6;
  localparam logic [31:0] P = 32'h0000_2024;
  localparam logic [31:0] IPM = ((32'd1 << N) - 32'd1) << 10;
  localparam logic [31:0] SRM = IPM | 32'd3;
`ifdef CP0_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0, en = 1'b0, BDIn = 1'b0, EXLClr = 1'b0;
  logic [4:0]  CP0_Addr = '0, ExcCodeIn = '0;
  logic [31:0] CP0_In = '0, VPC = '0;
  logic [N-1:0] HWInt = '0;
  logic [31:0] CP0_Out, EPC_Out;
  logic req, TimerIRQ;

  always #5 clk = ~clk;

  cp0_ext #(.HW_INT_N(N), .PRID(P)) dut (
    .clk(clk), .reset(reset), .en(en), .CP0_Addr(CP0_Addr), .CP0_In(CP0_In),
    .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .EXLClr(EXLClr),
    .CP0_Out(CP0_Out), .EPC_Out(EPC_Out), .req(req), .TimerIRQ(TimerIRQ)
  );

  typedef struct {
    logic        req;
    logic [31:0] rd;
    logic [31:0] epc;
    logic        tirq;
  } exp_t;

  exp_t sbq[$];
  int n_chk = 0, n_fail = 0;

  logic [31:0] m_sr, m_cause, m_epc, m_count, m_compare;
  bit m_tf, m_valid = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock of stimulus; expected outputs for this cycle go to the scoreboard, then the model advances.
  task automatic step(bit rst, bit e, int addr, logic [31:0] din, logic [31:0] vpc,
                      bit bd, int exc, logic [N-1:0] hw, bit clr);
    logic [31:0] ip, im, rd, hw_eff, code, bdb;
    bit ireq, ereq, mreq, wr, tf_n;
    exp_t x;
    @(posedge clk);
    #1;
    reset = rst; en = e; CP0_Addr = 5'(addr); CP0_In = din; VPC = vpc;
    BDIn = bd; ExcCodeIn = 5'(exc); HWInt = hw; EXLClr = clr;
    #1;
    if (m_valid) begin
      ip   = (m_cause & IPM) >> 10;
      im   = (m_sr & IPM) >> 10;
      ireq = ((ip & im) != 0) && m_sr[0] && !m_sr[1];
      ereq = (exc != 0) && !m_sr[1];
      mreq = ireq || ereq;
      case (addr)
        12: rd = m_sr;
        13: rd = m_cause;
        14: rd = m_epc;
        15: rd = P;
        9:  rd = TMR ? m_count : 32'd0;
        11: rd = TMR ? m_compare : 32'd0;
        default: rd = 32'd0;
      endcase
      x.req = mreq; x.rd = rd; x.epc = m_epc; x.tirq = TMR ? m_tf : 1'b0;
      sbq.push_back(x);
      if (!rst) begin
        wr     = e && !mreq;
        hw_eff = 32'(hw) | ((TMR && m_tf) ? (32'd1 << (N - 1)) : 32'd0);
        code   = (m_cause >> 2) & 32'h1F;
        bdb    = m_cause >> 31;
        if (mreq) begin
          m_sr  = m_sr | 32'd2;
          code  = ireq ? 32'd0 : 32'(exc);
          bdb   = 32'(bd);
          m_epc = (vpc - (vpc % 4)) - (bd ? 32'd4 : 32'd0);
        end else begin
          if (e && addr == 12) m_sr = din & SRM;
          if (e && addr == 14) m_epc = din;
          if (clr) m_sr = m_sr & ~32'd2;
        end
        m_cause = (bdb << 31) | (hw_eff << 10) | (code << 2);
        if (TMR) begin
          tf_n = (wr && addr == 11) ? 1'b0 : ((m_count == m_compare) ? 1'b1 : m_tf);
          m_count = (wr && addr == 9) ? din : m_count + 32'd1;
          if (wr && addr == 11) m_compare = din;
          m_tf = tf_n;
        end
      end
    end
    if (rst) begin
      m_sr = 0; m_cause = 0; m_epc = 0; m_count = 0; m_compare = 0; m_tf = 0;
      m_valid = 1'b1;
    end
  endtask

  task automatic idle(int addr);
    step(0, 0, addr, 0, 0, 0, 0, '0, 0);
  endtask

  // Reset, and in timer builds park Compare far away so the timer stays quiet.
  task automatic clean_reset();
    step(1, 0, 12, 0, 0, 0, 0, '0, 0);
    if (TMR) step(0, 1, 11, 32'hFFFF_0000, 0, 0, 0, '0, 0);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t x;
      x = sbq.pop_front();
      chk("sb_req",  32'(req), 32'(x.req));
      chk("sb_rd",   CP0_Out, x.rd);
      chk("sb_epc",  EPC_Out, x.epc);
      chk("sb_tirq", 32'(TimerIRQ), 32'(x.tirq));
    end
  end

  initial begin
    int al[8] = '{9, 11, 12, 13, 14, 15, 0, 3};
    // reset state
    step(1, 0, 12, 0, 0, 0, 0, '0, 0);
    idle(12);
    chk("rst_sr", CP0_Out, 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_tirq", 32'(TimerIRQ), 32'd0);
    idle(15);
    chk("prid", CP0_Out, P);
    idle(3);
    chk("unimpl", CP0_Out, 32'd0);

    // exception capture
    clean_reset();
    step(0, 1, 12, 32'h0000_FC01, 0, 0, 0, '0, 0);
    step(0, 0, 13, 0, 32'h3010, 0, 10, '0, 0);
    chk("exc_req", 32'(req), 32'd1);
    idle(13);
    chk("exc_epc", EPC_Out, 32'h3010);
    chk("exc_code", 32'(CP0_Out[6:2]), 32'd10);
    idle(12);
    chk("exc_sr", CP0_Out, 32'h0000_FC03);

    // interrupt in delay slot, then masking and eret
    clean_reset();
    step(0, 1, 12, 32'h0000_0401, 0, 0, 0, '0, 0);
    step(0, 0, 13, 0, 32'h3024, 1, 0, N'(1), 0);
    chk("int_req_lat", 32'(req), 32'd0);
    step(0, 0, 13, 0, 32'h3024, 1, 0, N'(1), 0);
    chk("int_req", 32'(req), 32'd1);
    idle(13);
    chk("int_epc", EPC_Out, 32'h3020);
    chk("int_cause", CP0_Out, 32'h8000_0400);
    step(0, 0, 12, 0, 0, 0, 0, N'(1), 0);
    chk("exl_mask", 32'(req), 32'd0);
    step(0, 0, 12, 0, 0, 0, 0, N'(1), 1);
    chk("eret_req", 32'(req), 32'd0);
    step(0, 0, 12, 0, 32'h4000, 0, 0, N'(1), 0);
    chk("eret_sr", CP0_Out, 32'h0000_0401);
    chk("eret_rereq", 32'(req), 32'd1);

    // mtc0 collides with an exception
    clean_reset();
    step(0, 1, 12, 32'h0000_FC01, 0, 0, 0, '0, 0);
    step(0, 1, 12, 32'h0, 32'h5000, 0, 12, '0, 0);
    chk("coll_req", 32'(req), 32'd1);
    idle(12);
    chk("coll_sr", CP0_Out, 32'h0000_FC03);
    idle(13);
    chk("coll_code", 32'(CP0_Out[6:2]), 32'd12);

    // timer
    clean_reset();
`ifdef CP0_TIMER_EN
    step(0, 1, 9, 32'd5, 0, 0, 0, '0, 0);
    step(0, 1, 11, 32'd8, 0, 0, 0, '0, 0);
    idle(9);
    idle(9);
    idle(9);
    chk("tmr_cnt8", CP0_Out, 32'd8);
    chk("tmr_pre", 32'(TimerIRQ), 32'd0);
    idle(9);
    chk("tmr_irq", 32'(TimerIRQ), 32'd1);
    step(0, 1, 11, 32'h100, 0, 0, 0, '0, 0);
    idle(11);
    chk("tmr_clr", 32'(TimerIRQ), 32'd0);
    step(0, 1, 9, 32'hFFFF_FFFF, 0, 0, 0, '0, 0);
    idle(9);
    chk("tmr_max", CP0_Out, 32'hFFFF_FFFF);
    idle(9);
    chk("tmr_wrap", CP0_Out, 32'd0);
`else
    step(0, 1, 9, 32'h1234, 0, 0, 0, '0, 0);
    step(0, 1, 11, 32'h5678, 0, 0, 0, '0, 0);
    idle(9);
    chk("notmr_cnt", CP0_Out, 32'd0);
    idle(11);
    chk("notmr_cmp", CP0_Out, 32'd0);
    chk("notmr_irq", 32'(TimerIRQ), 32'd0);
`endif

    // reset while an exception is being requested
    clean_reset();
    step(0, 1, 12, 32'h0000_FC01, 0, 0, 0, '0, 0);
    step(0, 1, 14, 32'hDEAD_BEEC, 0, 0, 0, '0, 0);
    step(1, 0, 12, 0, 32'h7000, 0, 5, '0, 0);
    chk("rstx_req_pre", 32'(req), 32'd1);
    idle(12);
    chk("rstx_sr", CP0_Out, 32'd0);
    chk("rstx_req", 32'(req), 32'd0);
    idle(13);
    chk("rstx_cause", CP0_Out, 32'd0);
    idle(14);
    chk("rstx_epc", CP0_Out, 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, al[$urandom_range(0, 7)],
           $urandom, $urandom, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 31)) : 0,
           ($urandom_range(0, 3) == 0) ? N'($urandom) : '0,
           $urandom_range(0, 7) == 0);
    end

    idle(0);
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cp0_ext.md
CP0_EXT -- requirements
Module: cp0_ext

Interface
REQ-001 SHALL have parameter HW_INT_N, default 6, giving the number of hardware interrupt lines (legal range 1..6).
REQ-002 SHALL have parameter PRID, default 32'h0000_2024, giving the read-only PRId value.
REQ-003 SHALL have port clk, input, 1 bit: single system clock, all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: mtc0 write enable.
REQ-006 SHALL have port CP0_Addr, input, 5 bits: register number for read and write.
REQ-007 SHALL have port CP0_In, input, 32 bits: mtc0 write data.
REQ-008 SHALL have port VPC, input, 32 bits: PC of the victim instruction.
REQ-009 SHALL have port BDIn, input, 1 bit: victim instruction is in a delay slot.
REQ-010 SHALL have port ExcCodeIn, input, 5 bits: synchronous exception code; 0 means none.
REQ-011 SHALL have port HWInt, input, HW_INT_N bits: level-sensitive external interrupt lines.
REQ-012 SHALL have port EXLClr, input, 1 bit: eret, clears SR.EXL.
REQ-013 SHALL have port CP0_Out, output, 32 bits: combinational read data.
REQ-014 SHALL have port EPC_Out, output, 32 bits: current EPC register value.
REQ-015 SHALL have port req, output, 1 bit: combinational exception/interrupt request to the PC and pipeline.
REQ-016 SHALL have port TimerIRQ, output, 1 bit: timer pending flag (0 when the timer is compiled out).

Function
REQ-017 SHALL implement these registers:
- SR (12): IM at [10+HW_INT_N-1:10], EXL at [1], IE at [0]; other bits read 0.
- Cause (13): BD at [31], IP at [10+HW_INT_N-1:10], ExcCode at [6:2]; other bits read 0.
- EPC (14).
- PRId (15) = PRID.
- Reads of any other address SHALL return 0.
REQ-018 SHALL sample Cause.IP from HWInt every cycle (registered, 1-cycle latency), with TimerIRQ ORed into line HW_INT_N-1.
REQ-019 SHALL define IntReq = |(Cause.IP & SR.IM) & SR.IE & !SR.EXL and ExcReq = (ExcCodeIn != 0) & !SR.EXL, with req = IntReq | ExcReq.
REQ-020 SHALL, on the edge where req=1:
- set EXL=1;
- set Cause.ExcCode to 0 if IntReq, else to ExcCodeIn (interrupt has priority);
- set Cause.BD = BDIn;
- set EPC = {VPC[31:2],2'b00} minus (BDIn ? 4 : 0).
REQ-021 SHALL drop any mtc0 write (en=1) in a cycle where req=1.
REQ-022 SHALL, on EXLClr=1 with req=0, clear EXL on the next edge.
REQ-023 SHALL give req priority over a simultaneous EXLClr.
REQ-024 SHALL, on mtc0 (en=1, req=0), write only SR, EPC, Count and Compare; writes to Cause and PRId SHALL be ignored, as SHALL writes to unimplemented SR bits.
REQ-025 SHALL present the EPC register value on EPC_Out; an EPC write SHALL become visible on the next cycle.

Reset
REQ-026 SHALL, with reset=1 at a clock edge, clear SR, Cause, EPC, Count, Compare and the timer flag to 0, leaving CP0_Out=0 for address 12/13/14, req=0 and TimerIRQ=0.
REQ-027 SHALL give reset priority over req, en and EXLClr in the same cycle.

Configuration
REQ-028 SHALL, when CP0_TIMER_EN is defined, implement:
- Count (9), a 32-bit counter incrementing every cycle and wrapping 0xFFFFFFFF->0;
- Compare (11);
- a pending flag that sets on the edge after Count==Compare and clears on any Compare write, with the write winning over a simultaneous match.
REQ-029 SHALL, when CP0_TIMER_EN is undefined, omit Count, Compare and the flag: addresses 9 and 11 read 0, writes to them are ignored, and TimerIRQ=0.

Verification
REQ-030 SHALL cover exception capture: SR=0x0000FC01, ExcCodeIn=10, VPC=0x3010, BDIn=0 -> req=1 same cycle; next cycle EPC=0x3010, Cause[6:2]=10, SR.EXL=1.
REQ-031 SHALL cover interrupt with delay slot: SR=0x00000401, HWInt[0]=1, BDIn=1, VPC=0x3024 -> req 1 cycle after HWInt rises; EPC=0x3020, Cause=0x80000400.
REQ-032 SHALL cover masking and eret: EXL=1 with HWInt active -> req=0; EXLClr pulse -> EXL=0 and req=1 the following cycle.
REQ-033 SHALL cover write/req collision: mtc0 SR=0 in the same cycle as ExcCodeIn=12 -> SR unchanged except EXL=1; ExcCode=12.
REQ-034 SHALL cover the timer (CP0_TIMER_EN): write Count=5, Compare=8 -> TimerIRQ=1 after Count reaches 8; rewriting Compare clears it; Count=0xFFFFFFFF wraps to 0.
REQ-035 SHALL cover reset mid-exception: reset=1 while req=1 -> all registers 0 and req=0 after the edge.
